// File: rtl/icmp_rx_pkg.sv
// rtl/icmp_rx_pkg.sv - shared ICMP constants, user-field layout and FSM states
package icmp_rx_pkg;

    localparam logic [7:0] ICMP_ECHO_REQ = 8'd8;
    localparam logic [7:0] ICMP_ECHO_REP = 8'd0;
    localparam logic [7:0] IP_PROTO_ICMP = 8'd1;

    // Bit positions inside s_axis_ip_user
    localparam int USER_LEN_LSB    = 40;
    localparam int USER_FLAG_LSB   = 37;
    localparam int USER_PROTO_LSB  = 29;
    localparam int USER_OFFSET_LSB = 16;
    localparam int USER_ID_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_DROP,
        ST_CHECK
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, k[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/icmp_cksum_acc.sv
// rtl/icmp_cksum_acc.sv - masked 4-word ones-complement accumulator with two-stage fold
module icmp_cksum_acc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [63:0] i_data,
    input  logic [7:0]  i_keep,
    output logic [15:0] o_fold
);

    logic [63:0] masked;
    logic [17:0] beat_sum;
    logic [31:0] sum_d, sum_q;
    logic [16:0] fold1;

    always_comb begin
        masked = 64'd0;
        for (int i = 0; i < 8; i++) begin
            masked[8*i +: 8] = i_data[8*i +: 8] & {8{i_keep[i]}};
        end
        beat_sum = {2'b00, masked[63:48]} + {2'b00, masked[47:32]}
                 + {2'b00, masked[31:16]} + {2'b00, masked[15:0]};
    end

    // Clear together with enable loads the first beat directly
    always_comb begin
        sum_d = sum_q;
        if (i_en) begin
            sum_d = (i_clr ? 32'd0 : sum_q) + {14'd0, beat_sum};
        end else if (i_clr) begin
            sum_d = 32'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign fold1  = {1'b0, sum_q[31:16]} + {1'b0, sum_q[15:0]};
    assign o_fold = fold1[15:0] + {15'd0, fold1[16]};

endmodule

// File: rtl/icmp_rx.sv
// rtl/icmp_rx.sv - receive-side ICMP parser: checksum check and echo event reporting
module icmp_rx
    import icmp_rx_pkg::*;
#(
    parameter int         P_CNT_W = 16,
    parameter logic [7:0] P_PROTO = IP_PROTO_ICMP
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [63:0]        s_axis_ip_data,
    input  logic [55:0]        s_axis_ip_user,
    input  logic [7:0]         s_axis_ip_keep,
    input  logic               s_axis_ip_last,
    input  logic               s_axis_ip_valid,
    output logic               s_axis_ip_ready,
    output logic               o_echo_req_valid,
    output logic               o_echo_rep_valid,
    output logic [15:0]        o_identifier,
    output logic [15:0]        o_sequence,
    output logic [15:0]        o_payload_len,
    output logic               o_cksum_err,
    output logic               o_len_err,
    output logic [P_CNT_W-1:0] o_rx_cnt,
    output logic [P_CNT_W-1:0] o_err_cnt
);

    state_t state_d, state_q;
    logic [7:0]  type_d, type_q, code_d, code_q;
    logic [15:0] id_d, id_q, seq_d, seq_q, cnt_d, cnt_q;
    logic        req_d, req_q, rep_d, rep_q, ck_d, ck_q, len_d, len_q;
    logic [15:0] oid_d, oid_q, oseq_d, oseq_q, olen_d, olen_q;
    logic [P_CNT_W-1:0] rx_d, rx_q, err_d, err_q;
    logic        ready, beat, drop, acc_en, acc_clr;
    logic [15:0] fold;
    logic [15:0] beat_bytes;
    logic        unused_user;

    assign ready = !i_rst && (state_q != ST_CHECK);
    assign beat  = s_axis_ip_valid && ready;
    assign beat_bytes = {12'd0, popcount8(s_axis_ip_keep)};
    assign drop  = (s_axis_ip_user[USER_PROTO_LSB +: 8] != P_PROTO)
                 || s_axis_ip_user[USER_FLAG_LSB]
                 || (s_axis_ip_user[USER_OFFSET_LSB +: 13] != 13'd0);
    assign unused_user = ^{s_axis_ip_user[USER_LEN_LSB +: 16],
                           s_axis_ip_user[USER_FLAG_LSB+1 +: 2],
                           s_axis_ip_user[USER_ID_LSB +: 16]};

    icmp_cksum_acc u_acc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (acc_clr),
        .i_en   (acc_en),
        .i_data (s_axis_ip_data),
        .i_keep (s_axis_ip_keep),
        .o_fold (fold)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        code_d  = code_q;
        id_d    = id_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;
        rep_d   = 1'b0;
        ck_d    = 1'b0;
        len_d   = 1'b0;
        oid_d   = oid_q;
        oseq_d  = oseq_q;
        olen_d  = olen_q;
        rx_d    = rx_q;
        err_d   = err_q;
        acc_en  = 1'b0;
        acc_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    if (drop) begin
                        state_d = s_axis_ip_last ? ST_IDLE : ST_DROP;
                    end else begin
                        acc_en  = 1'b1;
                        acc_clr = 1'b1;
                        cnt_d   = beat_bytes;
                        type_d  = s_axis_ip_data[63:56];
                        code_d  = s_axis_ip_data[55:48];
                        id_d    = s_axis_ip_data[31:16];
                        seq_d   = s_axis_ip_data[15:0];
                        state_d = s_axis_ip_last ? ST_CHECK : ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (beat) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q + beat_bytes;
                    if (s_axis_ip_last) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_DROP: begin
                if (beat && s_axis_ip_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (cnt_q < 16'd8) begin
                    len_d = 1'b1;
                    if (err_q != {P_CNT_W{1'b1}}) err_d = err_q + 1'b1;
                end else if (fold != 16'hFFFF) begin
                    ck_d = 1'b1;
                    if (err_q != {P_CNT_W{1'b1}}) err_d = err_q + 1'b1;
                end else if (code_q == 8'd0 &&
                             (type_q == ICMP_ECHO_REQ || type_q == ICMP_ECHO_REP)) begin
                    req_d  = (type_q == ICMP_ECHO_REQ);
                    rep_d  = (type_q == ICMP_ECHO_REP);
                    oid_d  = id_q;
                    oseq_d = seq_q;
                    olen_d = cnt_q - 16'd8;
                    if (rx_q != {P_CNT_W{1'b1}}) rx_d = rx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            type_q  <= 8'd0;
            code_q  <= 8'd0;
            id_q    <= 16'd0;
            seq_q   <= 16'd0;
            cnt_q   <= 16'd0;
            req_q   <= 1'b0;
            rep_q   <= 1'b0;
            ck_q    <= 1'b0;
            len_q   <= 1'b0;
            oid_q   <= 16'd0;
            oseq_q  <= 16'd0;
            olen_q  <= 16'd0;
            rx_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            code_q  <= code_d;
            id_q    <= id_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rep_q   <= rep_d;
            ck_q    <= ck_d;
            len_q   <= len_d;
            oid_q   <= oid_d;
            oseq_q  <= oseq_d;
            olen_q  <= olen_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
        end
    end

    assign s_axis_ip_ready  = ready;
    assign o_echo_req_valid = req_q;
    assign o_echo_rep_valid = rep_q;
    assign o_cksum_err      = ck_q;
    assign o_len_err        = len_q;
    assign o_identifier     = oid_q;
    assign o_sequence       = oseq_q;
    assign o_payload_len    = olen_q;
    assign o_rx_cnt         = rx_q;
    assign o_err_cnt        = err_q;

endmodule

// File: tb/tb_icmp_rx.sv
// tb/tb_icmp_rx.sv - randomized scoreboard bench for icmp_rx against a byte-level ICMP model
module tb_icmp_rx;

    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [63:0]   s_data = '0;
    logic [55:0]   s_user = '0;
    logic [7:0]    s_keep = '0;
    logic          s_last = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          o_echo_req_valid, o_echo_rep_valid, o_cksum_err, o_len_err;
    logic [15:0]   o_identifier, o_sequence, o_payload_len;
    logic [CW-1:0] o_rx_cnt, o_err_cnt;

    icmp_rx #(.P_CNT_W(CW), .P_PROTO(8'd1)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .s_axis_ip_data   (s_data),
        .s_axis_ip_user   (s_user),
        .s_axis_ip_keep   (s_keep),
        .s_axis_ip_last   (s_last),
        .s_axis_ip_valid  (s_valid),
        .s_axis_ip_ready  (s_ready),
        .o_echo_req_valid (o_echo_req_valid),
        .o_echo_rep_valid (o_echo_rep_valid),
        .o_identifier     (o_identifier),
        .o_sequence       (o_sequence),
        .o_payload_len    (o_payload_len),
        .o_cksum_err      (o_cksum_err),
        .o_len_err        (o_len_err),
        .o_rx_cnt         (o_rx_cnt),
        .o_err_cnt        (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int edge_cnt = 0;
    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // kind bits: [3]=echo req, [2]=echo rep, [1]=cksum err, [0]=len err
    typedef struct {
        logic [3:0]  kind;
        int          edge_no;
        logic [15:0] id;
        logic [15:0] seq;
        logic [15:0] len;
        int          rx;
        int          err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] msg[$];
    int         model_rx = 0;
    int         model_err = 0;
    bit         expect_bubble = 0;

    always @(negedge i_clk) begin
        logic [3:0] k;
        exp_t e;
        k = {o_echo_req_valid, o_echo_rep_valid, o_cksum_err, o_len_err};
        if (k != 4'd0) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {28'd0, k}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {28'd0, k}, {28'd0, e.kind});
                check("event_latency", edge_cnt, e.edge_no);
                if (e.kind[3] || e.kind[2]) begin
                    check("identifier", {16'd0, o_identifier}, {16'd0, e.id});
                    check("sequence", {16'd0, o_sequence}, {16'd0, e.seq});
                    check("payload_len", {16'd0, o_payload_len}, {16'd0, e.len});
                end
                check("rx_cnt", {29'd0, o_rx_cnt}, e.rx);
                check("err_cnt", {29'd0, o_err_cnt}, e.err);
            end
        end else if (sb.size() > 0 && edge_cnt > sb[0].edge_no) begin
            check("missed_event", {28'd0, k}, {28'd0, sb[0].kind});
            void'(sb.pop_front());
        end
    end

    function automatic logic [15:0] msg_fold();
        int unsigned s;
        s = 0;
        for (int i = 0; i < msg.size(); i += 2) begin
            s += {msg[i], (i + 1 < msg.size()) ? msg[i+1] : 8'h00};
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    task automatic build_echo(input logic [7:0] t, input logic [7:0] c, input logic [15:0] id,
                              input logic [15:0] seq, input int plen, input bit corrupt);
        logic [15:0] cs;
        msg.delete();
        msg.push_back(t);
        msg.push_back(c);
        msg.push_back(8'h00);
        msg.push_back(8'h00);
        msg.push_back(id[15:8]);
        msg.push_back(id[7:0]);
        msg.push_back(seq[15:8]);
        msg.push_back(seq[7:0]);
        for (int i = 0; i < plen; i++) msg.push_back(8'($urandom));
        cs = ~msg_fold();
        msg[2] = cs[15:8];
        msg[3] = cs[7:0] ^ {7'd0, corrupt};
    endtask

    task automatic build_raw(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    function automatic logic [55:0] mk_user(input logic [7:0] proto, input logic [2:0] flag,
                                            input logic [12:0] off);
        return {16'(msg.size()), flag, proto, off, 16'hBEEF};
    endfunction

    task automatic make_beat(input int b, output logic [63:0] d, output logic [7:0] k);
        d = '0;
        k = '0;
        for (int j = 0; j < 8; j++) begin
            if (b * 8 + j < msg.size()) begin
                d[63-8*j -: 8] = msg[b*8+j];
                k[7-j] = 1'b1;
            end else begin
                d[63-8*j -: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [55:0] u, input int exp_stall, output int le);
        int stalls;
        stalls = 0;
        s_data = d;
        s_keep = k;
        s_last = l;
        s_user = u;
        s_valid = 1'b1;
        while (!s_ready && stalls < 20) begin
            @(negedge i_clk);
            stalls++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
        s_valid = 1'b0;
        le = edge_cnt;
        check("ready_stall", stalls, exp_stall);
    endtask

    task automatic send_pkt(input logic [55:0] u, input bit gaps);
        int nb, le, n;
        logic [63:0] d;
        logic [7:0] k;
        bit accepted;
        exp_t e;
        n = msg.size();
        nb = (n + 7) / 8;
        le = 0;
        accepted = (u[36:29] == 8'd1) && !u[37] && (u[28:16] == 13'd0);
        for (int b = 0; b < nb; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge i_clk);
                if (b == 0) expect_bubble = 0;
            end
            make_beat(b, d, k);
            send_beat(d, k, b == nb - 1, u, (b == 0 && expect_bubble) ? 1 : 0, le);
        end
        expect_bubble = accepted;
        if (accepted) begin
            e.kind = 4'd0;
            if (n < 8) e.kind = 4'b0001;
            else if (msg_fold() != 16'hFFFF) e.kind = 4'b0010;
            else if (msg[1] == 8'd0 && msg[0] == 8'd8) e.kind = 4'b1000;
            else if (msg[1] == 8'd0 && msg[0] == 8'd0) e.kind = 4'b0100;
            if (e.kind[1:0] != 2'b00 && model_err < CMAX) model_err++;
            if (e.kind[3:2] != 2'b00 && model_rx < CMAX) model_rx++;
            if (e.kind != 4'd0) begin
                e.edge_no = le + 1;
                e.id  = (n >= 8) ? {msg[4], msg[5]} : 16'd0;
                e.seq = (n >= 8) ? {msg[6], msg[7]} : 16'd0;
                e.len = 16'(n - 8);
                e.rx  = model_rx;
                e.err = model_err;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        logic [7:0] k;
        int le;
        int r;
        repeat (3) @(negedge i_clk);
        check("reset_ready", {31'd0, s_ready}, 32'd0);
        check("reset_pulses", {28'd0, o_echo_req_valid, o_echo_rep_valid, o_cksum_err, o_len_err}, 32'd0);
        check("reset_outs", {o_identifier, o_sequence}, 32'd0);
        check("reset_cnts", {10'd0, o_payload_len, o_rx_cnt, o_err_cnt}, 32'd0);
        i_rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, s_ready}, 32'd1);
        @(negedge i_clk);

        build_echo(8'd8, 8'd0, 16'h0001, 16'h0005, 32, 0);
        send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);
        build_echo(8'd8, 8'd0, 16'h0001, 16'h0005, 32, 1);
        send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);
        build_raw(24);
        send_pkt(mk_user(8'd17, 3'd0, 13'd0), 0);
        build_echo(8'd0, 8'd0, 16'hA5C3, 16'h0102, 13, 0);
        send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);
        build_raw(4);
        send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);
        build_echo(8'd8, 8'd0, 16'h1111, 16'h0001, 16, 0);
        send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);
        build_echo(8'd8, 8'd0, 16'h1111, 16'h0002, 7, 0);
        send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);
        repeat (4) @(negedge i_clk);

        build_echo(8'd8, 8'd0, 16'h7777, 16'h0009, 32, 0);
        for (int b = 0; b < 2; b++) begin
            make_beat(b, d, k);
            send_beat(d, k, 1'b0, mk_user(8'd1, 3'd0, 13'd0), 0, le);
        end
        make_beat(2, d, k);
        s_data = d;
        s_keep = k;
        s_valid = 1'b1;
        i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        check("midrst_ready", {31'd0, s_ready}, 32'd0);
        check("midrst_pulses", {28'd0, o_echo_req_valid, o_echo_rep_valid, o_cksum_err, o_len_err}, 32'd0);
        check("midrst_outs", {o_identifier, o_sequence}, 32'd0);
        check("midrst_cnts", {10'd0, o_payload_len, o_rx_cnt, o_err_cnt}, 32'd0);
        s_valid = 1'b0;
        i_rst = 1'b0;
        model_rx = 0;
        model_err = 0;
        expect_bubble = 0;
        @(negedge i_clk);
        build_echo(8'd8, 8'd0, 16'h2468, 16'h1357, 20, 0);
        send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);

        for (int p = 0; p < 60; p++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: begin
                    build_raw($urandom_range(1, 30));
                    send_pkt(mk_user(8'($urandom_range(2, 255)), 3'd0, 13'd0), 1);
                end
                1: begin
                    build_echo(8'd8, 8'd0, 16'($urandom), 16'($urandom), $urandom_range(0, 30), 0);
                    send_pkt(mk_user(8'd1, 3'b001, 13'd0), 1);
                end
                2: begin
                    build_echo(8'd8, 8'd0, 16'($urandom), 16'($urandom), $urandom_range(0, 30), 0);
                    send_pkt(mk_user(8'd1, 3'd0, 13'($urandom_range(1, 8191))), 1);
                end
                3: begin
                    build_raw($urandom_range(1, 7));
                    send_pkt(mk_user(8'd1, 3'b010, 13'd0), 1);
                end
                4: begin
                    build_echo(8'd0, 8'd0, 16'($urandom), 16'($urandom), $urandom_range(0, 40), 1);
                    send_pkt(mk_user(8'd1, 3'd0, 13'd0), 1);
                end
                default: begin
                    build_echo(($urandom_range(0, 4) == 0) ? 8'd3 : (($urandom_range(0, 1) == 0) ? 8'd0 : 8'd8),
                               ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0,
                               16'($urandom), 16'($urandom), $urandom_range(0, 40), 0);
                    send_pkt(mk_user(8'd1, 3'b100, 13'd0), 1);
                end
            endcase
        end

        for (int p = 0; p < 9; p++) begin
            build_echo(8'd8, 8'd0, 16'(p), 16'(p), $urandom_range(0, 20), 1);
            send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);
            build_echo(8'd0, 8'd0, 16'(p), 16'(p), $urandom_range(0, 20), 0);
            send_pkt(mk_user(8'd1, 3'd0, 13'd0), 0);
        end

        repeat (10) @(negedge i_clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("final_rx_cnt", {29'd0, o_rx_cnt}, model_rx);
        check("final_err_cnt", {29'd0, o_err_cnt}, model_err);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
